td4x_cpu: RTL and testbench
===========================

TD4X_CPU -- requirements
Module: td4x_cpu

Interface
REQ-001 Parameter DATA_W, default 4, SHALL set register, immediate, ALU and I/O port width.
REQ-002 Parameter ADDR_W, default 4, SHALL set program counter width; legal only when ADDR_W <= DATA_W.
REQ-003 CLK  input  1  SHALL be the single clock; all state updates on its rising edge.
REQ-004 RST  input  1  SHALL be the asynchronous, active-low reset.
REQ-005 run  input  1  SHALL enable execution of one instruction per cycle when 1; when 0, no architectural state changes.
REQ-006 instr_addr  output  ADDR_W  SHALL equal the current PC.
REQ-007 instr_data  input  DATA_W+4  SHALL be the instruction at instr_addr, valid in the same cycle: [DATA_W+3:DATA_W] opcode, [DATA_W-1:0] immediate Im.
REQ-008 in_port  input  DATA_W  SHALL be the sampled input port.
REQ-009 out_port  output  DATA_W  SHALL be the registered output port.
REQ-010 out_strobe  output  1  SHALL pulse high for exactly the cycle after each OUT instruction executes.
REQ-011 carry  output  1  SHALL reflect the C flag register.
REQ-012 halted  output  1  SHALL be 1 while the core is halted.

Function
REQ-013 Opcodes SHALL be: 0000 A=A+Im; 0101 B=B+Im; 0011 A=Im; 0111 B=Im; 0001 A=B+Im; 0100 B=A+Im; 0010 A=in_port+Im; 0110 B=in_port+Im; 1001 out_port=B+Im; 1011 out_port=Im; 1111 JMP; 1110 JNC; 1000 HALT; all others NOP.
REQ-014 All arithmetic SHALL be DATA_W-bit modulo 2^DATA_W; carry-out is bit DATA_W of the unsigned sum.
REQ-015 C SHALL update only on 0000 and 0101, taking that instruction's carry-out; all other instructions SHALL leave C unchanged.
REQ-016 JMP SHALL load PC with Im[ADDR_W-1:0]; JNC SHALL do the same when C=0, else PC+1.
REQ-017 Every other executed instruction SHALL advance PC by 1, wrapping from 2^ADDR_W-1 to 0.
REQ-018 Each instruction SHALL complete in one cycle; its results are visible on outputs the following cycle.
REQ-019 JNC SHALL test C as registered before the current edge, never a carry produced in the same cycle.
REQ-020 HALT SHALL set halted=1 and freeze PC at the HALT address; A, B, C and out_port hold. Only reset exits halt.
REQ-021 With run=0 or halted=1, out_strobe SHALL be 0 and all state SHALL hold.
REQ-022 Deasserting run mid-program and reasserting it SHALL resume at the held PC with no lost or repeated instruction.

Reset
REQ-023 RST=0 SHALL immediately, independent of CLK, force PC=0, A=0, B=0, C=0, out_port=0, out_strobe=0, halted=0.
REQ-024 Reset asserted mid-execution or while halted SHALL discard the in-flight instruction. Execution SHALL restart at address 0 on the first rising edge with RST=1 and run=1.

Verification
REQ-025 Default params, program {0011 0111, 0000 1010, 1110 0000, 1001 0000}: A=0111 -> A=0001, C=1 -> JNC not taken, PC=3 -> out_port=B+0=0000, out_strobe one cycle.
REQ-026 DATA_W=8, ADDR_W=6, A=0xFF, ADD A,0x01 -> A=0x00, C=1. A following ADD A,0x01 -> A=0x01, C=0.
REQ-027 Default params, sixteen NOPs -> PC steps 0..15 then 0; a JMP 1111 at address 5 -> next PC=15.
REQ-028 HALT at address 3, run held 1 for 10 cycles -> halted=1, instr_addr=3, no out_strobe. RST pulse low -> halted=0, PC=0.
REQ-029 run toggled 0 for 3 cycles after instruction 2 -> PC, A, B, C, out_port unchanged across gap; trace matches the uninterrupted run.
REQ-030 RST asserted asynchronously between edges during OUT -> out_port=0, out_strobe=0 before the next edge.

Source files
------------

// File: rtl/td4x_cpu.sv
// rtl/td4x_cpu.sv - TD4-style single-cycle 4-bit CPU core with parameterised data/address width
// One instruction executes per enabled clock; HALT is a sticky state left only through reset.
module td4x_cpu #(
   parameter int DATA_W = 4,
   parameter int ADDR_W = 4
) (
   input  logic              CLK,
   input  logic              RST,
   input  logic              run,
   output logic [ADDR_W-1:0] instr_addr,
   input  logic [DATA_W+3:0] instr_data,
   input  logic [DATA_W-1:0] in_port,
   output logic [DATA_W-1:0] out_port,
   output logic              out_strobe,
   output logic              carry,
   output logic              halted
);

   typedef enum logic {
      ST_RUN  = 1'b0,
      ST_HALT = 1'b1
   } state_t;

   typedef enum logic [1:0] {
      SRC_ZERO = 2'd0,
      SRC_A    = 2'd1,
      SRC_B    = 2'd2,
      SRC_IN   = 2'd3
   } src_t;

   state_t              r_state;
   state_t              w_state_nxt;
   logic [ADDR_W-1:0]   r_pc;
   logic [DATA_W-1:0]   r_a;
   logic [DATA_W-1:0]   r_b;
   logic                r_c;
   logic [DATA_W-1:0]   r_out;
   logic                r_strobe;

   logic [3:0]          w_op;
   logic [DATA_W-1:0]   w_im;
   src_t                w_src;
   logic [DATA_W-1:0]   w_src_val;
   logic [DATA_W:0]     w_sum;
   logic                w_wr_a;
   logic                w_wr_b;
   logic                w_wr_c;
   logic                w_wr_out;
   logic                w_jmp;
   logic                w_jnc;
   logic                w_halt;
   logic                w_exec;
   logic [ADDR_W-1:0]   w_pc_nxt;

   assign w_op   = instr_data[DATA_W+3:DATA_W];
   assign w_im   = instr_data[DATA_W-1:0];
   assign w_exec = run && (r_state == ST_RUN);

   always_comb begin
      w_src    = SRC_ZERO;
      w_wr_a   = 1'b0;
      w_wr_b   = 1'b0;
      w_wr_c   = 1'b0;
      w_wr_out = 1'b0;
      w_jmp    = 1'b0;
      w_jnc    = 1'b0;
      w_halt   = 1'b0;
      case (w_op)
         4'b0000: begin w_src = SRC_A;    w_wr_a = 1'b1; w_wr_c = 1'b1; end
         4'b0101: begin w_src = SRC_B;    w_wr_b = 1'b1; w_wr_c = 1'b1; end
         4'b0011: begin w_src = SRC_ZERO; w_wr_a = 1'b1; end
         4'b0111: begin w_src = SRC_ZERO; w_wr_b = 1'b1; end
         4'b0001: begin w_src = SRC_B;    w_wr_a = 1'b1; end
         4'b0100: begin w_src = SRC_A;    w_wr_b = 1'b1; end
         4'b0010: begin w_src = SRC_IN;   w_wr_a = 1'b1; end
         4'b0110: begin w_src = SRC_IN;   w_wr_b = 1'b1; end
         4'b1001: begin w_src = SRC_B;    w_wr_out = 1'b1; end
         4'b1011: begin w_src = SRC_ZERO; w_wr_out = 1'b1; end
         4'b1111: w_jmp  = 1'b1;
         4'b1110: w_jnc  = 1'b1;
         4'b1000: w_halt = 1'b1;
         default: ;
      endcase
   end

   always_comb begin
      w_src_val = '0;
      case (w_src)
         SRC_A:   w_src_val = r_a;
         SRC_B:   w_src_val = r_b;
         SRC_IN:  w_src_val = in_port;
         default: w_src_val = '0;
      endcase
   end

   // The extra MSB of the sum is the carry-out that loads C.
   assign w_sum = {1'b0, w_src_val} + {1'b0, w_im};

   // JNC looks at the registered C, so a carry from this same cycle never steers it.
   always_comb begin
      w_pc_nxt = r_pc + ADDR_W'(1);
      if (w_jmp || (w_jnc && !r_c)) begin
         w_pc_nxt = w_im[ADDR_W-1:0];
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      if (w_exec && w_halt) begin
         w_state_nxt = ST_HALT;
      end
   end

   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         r_state <= ST_RUN;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         r_pc     <= '0;
         r_a      <= '0;
         r_b      <= '0;
         r_c      <= 1'b0;
         r_out    <= '0;
         r_strobe <= 1'b0;
      end else begin
         r_strobe <= w_exec && w_wr_out;
         if (w_exec) begin
            if (!w_halt) begin
               r_pc <= w_pc_nxt;
            end
            if (w_wr_a) begin
               r_a <= w_sum[DATA_W-1:0];
            end
            if (w_wr_b) begin
               r_b <= w_sum[DATA_W-1:0];
            end
            if (w_wr_c) begin
               r_c <= w_sum[DATA_W];
            end
            if (w_wr_out) begin
               r_out <= w_sum[DATA_W-1:0];
            end
         end
      end
   end

   assign instr_addr = r_pc;
   assign out_port   = r_out;
   assign out_strobe = r_strobe;
   assign carry      = r_c;
   assign halted     = (r_state == ST_HALT);

endmodule

// File: tb/tb_td4x_cpu.sv
// tb/tb_td4x_cpu.sv - scoreboard bench for td4x_cpu (default and 8/6-bit instances)
module tb_td4x_cpu;

   logic        CLK;
   logic        RST;
   logic        run;
   logic [3:0]  instr_addr;
   logic [7:0]  instr_data;
   logic [3:0]  in_port;
   logic [3:0]  out_port;
   logic        out_strobe;
   logic        carry;
   logic        halted;

   logic        run8;
   logic [5:0]  addr8;
   logic [11:0] data8;
   logic [7:0]  in8;
   logic [7:0]  out8;
   logic        strobe8;
   logic        carry8;
   logic        halted8;

   logic [7:0]  rom  [16];
   logic [11:0] rom8 [64];

   logic [3:0]  exp_q  [$];
   logic [7:0]  exp8_q [$];

   int n_checks = 0;
   int n_err    = 0;

   int trace     [15];
   int exp_trace [15] = '{1, 2, 3, 4, 5, 6, 7, 8, 10, 11, 12, 13, 14, 15, 0};

   assign instr_data = rom[instr_addr];
   assign data8      = rom8[addr8];

   td4x_cpu dut (
      .CLK        (CLK),
      .RST        (RST),
      .run        (run),
      .instr_addr (instr_addr),
      .instr_data (instr_data),
      .in_port    (in_port),
      .out_port   (out_port),
      .out_strobe (out_strobe),
      .carry      (carry),
      .halted     (halted)
   );

   td4x_cpu #(.DATA_W(8), .ADDR_W(6)) dut8 (
      .CLK        (CLK),
      .RST        (RST),
      .run        (run8),
      .instr_addr (addr8),
      .instr_data (data8),
      .in_port    (in8),
      .out_port   (out8),
      .out_strobe (strobe8),
      .carry      (carry8),
      .halted     (halted8)
   );

   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   task automatic chk(input string name, input int act, input int exp);
      n_checks++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   // Monitor: every strobe must match the oldest outstanding expected output.
   always @(negedge CLK) begin
      if (out_strobe) begin
         if (exp_q.size() == 0) begin
            n_checks++;
            n_err++;
            $display("FAIL strobe4: unexpected strobe, out_port=%0d", out_port);
         end else begin
            chk("out4", int'(out_port), int'(exp_q.pop_front()));
         end
      end
      if (strobe8) begin
         if (exp8_q.size() == 0) begin
            n_checks++;
            n_err++;
            $display("FAIL strobe8: unexpected strobe, out_port=%0d", out8);
         end else begin
            chk("out8", int'(out8), int'(exp8_q.pop_front()));
         end
      end
   end

   task automatic step(input int n);
      repeat (n) begin
         @(posedge CLK);
         #1;
      end
   endtask

   task automatic do_rst();
      @(negedge CLK);
      #1;
      RST  = 1'b0;
      run  = 1'b0;
      run8 = 1'b0;
   endtask

   task automatic go();
      @(negedge CLK);
      #1;
      RST = 1'b1;
      run = 1'b1;
   endtask

   task automatic pause();
      @(negedge CLK);
      #1;
      run = 1'b0;
   endtask

   task automatic fill_nop();
      for (int i = 0; i < 16; i++) rom[i] = 8'hC0;
   endtask

   task automatic load_main();
      fill_nop();
      rom[0]  = 8'h35;  rom[1]  = 8'h73;  rom[2]  = 8'h42;  rom[3]  = 8'h91;
      rom[4]  = 8'h0C;  rom[5]  = 8'h10;  rom[6]  = 8'hE9;  rom[7]  = 8'h52;
      rom[8]  = 8'hEA;  rom[9]  = 8'hBF;  rom[10] = 8'h91;  rom[11] = 8'h20;
      rom[12] = 8'h65;  rom[13] = 8'h90;  rom[14] = 8'h40;  rom[15] = 8'h93;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      RST = 1'b1; run = 1'b0; run8 = 1'b0; in_port = 4'd0; in8 = 8'd0;
      fill_nop();
      for (int i = 0; i < 64; i++) rom8[i] = 12'hC00;
      #1 RST = 1'b0;
      #1;
      chk("rst_pc",     int'(instr_addr), 0);
      chk("rst_out",    int'(out_port),   0);
      chk("rst_strobe", int'(out_strobe), 0);
      chk("rst_carry",  int'(carry),      0);
      chk("rst_halted", int'(halted),     0);
      chk("rst8_pc",    int'(addr8),      0);

      // Carry from ADD suppresses the following JNC; OUT then prints B.
      rom[0] = 8'h37; rom[1] = 8'h0A; rom[2] = 8'hE0; rom[3] = 8'h90; rom[4] = 8'h80;
      exp_q.push_back(4'd0);
      go();
      step(2);
      chk("add_carry", int'(carry), 1);
      chk("add_pc",    int'(instr_addr), 2);
      step(1);
      chk("jnc_not_taken_pc", int'(instr_addr), 3);
      step(1);
      chk("out_pc", int'(instr_addr), 4);
      step(1);
      chk("halt_after_out", int'(halted), 1);

      // Sixteen NOPs wrap the PC; then a JMP from address 5.
      do_rst();
      fill_nop();
      go();
      for (int i = 0; i < 16; i++) begin
         step(1);
         chk("nop_pc", int'(instr_addr), (i + 1) % 16);
      end
      do_rst();
      rom[5] = 8'hFF;
      go();
      step(5);
      chk("jmp_src_pc", int'(instr_addr), 5);
      step(1);
      chk("jmp_dst_pc", int'(instr_addr), 15);

      // HALT at address 3 holds until reset; reset acts without a clock.
      do_rst();
      fill_nop();
      rom[3] = 8'h80;
      go();
      step(10);
      chk("halt_flag", int'(halted), 1);
      chk("halt_pc",   int'(instr_addr), 3);
      @(negedge CLK);
      #1 RST = 1'b0;
      #1;
      chk("halt_rst_flag", int'(halted), 0);
      chk("halt_rst_pc",   int'(instr_addr), 0);

      // Mixed program, uninterrupted, recording the PC trace.
      do_rst();
      load_main();
      in_port = 4'd6;
      exp_q.push_back(4'd8);  exp_q.push_back(4'd10);
      exp_q.push_back(4'd11); exp_q.push_back(4'd9);
      go();
      for (int i = 0; i < 15; i++) begin
         step(1);
         trace[i] = int'(instr_addr);
         chk("trace_pc", trace[i], exp_trace[i]);
         if (i == 4) chk("main_carry_set", int'(carry), 1);
         if (i == 7) chk("main_carry_clr", int'(carry), 0);
      end
      pause();
      chk("main_final_out", int'(out_port), 9);

      // Same program with a three-cycle run gap after instruction 2.
      do_rst();
      exp_q.push_back(4'd8);  exp_q.push_back(4'd10);
      exp_q.push_back(4'd11); exp_q.push_back(4'd9);
      go();
      for (int i = 0; i < 3; i++) begin
         step(1);
         chk("gap_trace_pc", int'(instr_addr), trace[i]);
      end
      pause();
      for (int i = 0; i < 3; i++) begin
         step(1);
         chk("gap_hold_pc",     int'(instr_addr), 3);
         chk("gap_hold_carry",  int'(carry), 0);
         chk("gap_hold_strobe", int'(out_strobe), 0);
      end
      @(negedge CLK);
      #1 run = 1'b1;
      for (int i = 3; i < 15; i++) begin
         step(1);
         chk("gap_trace_pc", int'(instr_addr), trace[i]);
         if (i == 4) chk("gap_carry_set", int'(carry), 1);
      end
      pause();
      chk("gap_final_out", int'(out_port), 9);

      // Asynchronous reset while an OUT is in flight.
      do_rst();
      fill_nop();
      rom[0] = 8'hB5; rom[1] = 8'hB9;
      exp_q.push_back(4'd5);
      go();
      step(1);
      chk("aout_first", int'(out_port), 5);
      @(negedge CLK);
      #1 RST = 1'b0;
      #1;
      chk("aout_rst_out",    int'(out_port), 0);
      chk("aout_rst_strobe", int'(out_strobe), 0);
      chk("aout_rst_pc",     int'(instr_addr), 0);
      step(1);
      chk("aout_held_out", int'(out_port), 0);
      exp_q.push_back(4'd5);
      @(negedge CLK);
      #1 RST = 1'b1;
      step(1);
      chk("aout_restart_out", int'(out_port), 5);
      chk("aout_restart_pc",  int'(instr_addr), 1);
      pause();

      // Wide instance: 8-bit wrap carry, carry clear, OUT and 6-bit jump target.
      do_rst();
      rom8[0] = 12'h3FF; rom8[1] = 12'h001; rom8[2] = 12'h400; rom8[3] = 12'h900;
      rom8[4] = 12'h001; rom8[5] = 12'h400; rom8[6] = 12'h9A0; rom8[7] = 12'hFC9;
      rom8[8] = 12'hBEE; rom8[9] = 12'h800;
      exp8_q.push_back(8'h00);
      exp8_q.push_back(8'hA1);
      @(negedge CLK);
      #1;
      RST  = 1'b1;
      run8 = 1'b1;
      step(2);
      chk("w8_carry_set", int'(carry8), 1);
      step(3);
      chk("w8_carry_clr", int'(carry8), 0);
      step(4);
      chk("w8_jmp_halt_pc", int'(addr8),   9);
      chk("w8_halted",      int'(halted8), 1);
      step(2);
      chk("w8_halt_hold_pc", int'(addr8), 9);
      chk("w8_out_hold",     int'(out8),  8'hA1);
      run8 = 1'b0;

      step(2);
      chk("q4_drained", exp_q.size(), 0);
      chk("q8_drained", exp8_q.size(), 0);
      $display("Result: errors=%0d of %0d checks", n_err, n_checks);
      $finish;
   end

endmodule
